// File: rtl/vgafb_fetch.sv
// Burst fetch scheduler for the VGA framebuffer pixel FIFO: issues 2-beat
// 32-bit read bursts walking one frame linearly and forwards each beat to the FIFO.
module vgafb_fetch #(
    parameter int fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 enable,
    input  logic [fml_depth-1:0] baseaddress,
    input  logic [17:0]          nbursts,
    output logic                 base_ack,
    input  logic                 fifo_can_burst,
    output logic                 fifo_stb,
    output logic [31:0]          fifo_di,
    output logic                 mem_stb,
    output logic [fml_depth-1:0] mem_adr,
    input  logic                 mem_ack,
    input  logic                 mem_dv,
    input  logic [31:0]          mem_di
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_SETTLE
    } state_t;

    state_t               r_state;
    logic [17:0]          r_offset;
    logic [fml_depth-1:0] r_base_cur;
    logic                 r_beat;
    logic                 r_base_ack;
    logic                 r_fifo_stb;
    logic [31:0]          r_fifo_di;
    logic                 r_mem_stb;
    logic [fml_depth-1:0] r_mem_adr;

    logic [fml_depth-1:0] w_base_in;
    logic [fml_depth-1:0] w_next_adr;
    logic [17:0]          w_nb_eff;
    logic [18:0]          w_off_inc;
    logic                 w_wrap;
    logic                 w_unused;

    // Bursts are 8-byte aligned, so the low address bits never reach the bus.
    assign w_base_in  = {baseaddress[fml_depth-1:3], 3'b000};
    assign w_unused   = ^baseaddress[2:0];
    assign w_next_adr = r_base_cur + fml_depth'({r_offset, 3'b000});
    assign w_nb_eff   = (nbursts == 18'd0) ? 18'd1 : nbursts;
    assign w_off_inc  = {1'b0, r_offset} + 19'd1;
    assign w_wrap     = (w_off_inc >= {1'b0, w_nb_eff});

    // NOTE: every state register uses <= so all branches see the pre-edge values,
    // and the async reset clears the outputs without waiting for a clock.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_offset   <= '0;
            r_base_cur <= '0;
            r_beat     <= 1'b0;
            r_base_ack <= 1'b0;
            r_fifo_stb <= 1'b0;
            r_fifo_di  <= '0;
            r_mem_stb  <= 1'b0;
            r_mem_adr  <= '0;
        end else begin
            r_fifo_stb <= 1'b0;
            r_base_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && fifo_can_burst) begin
                        r_mem_adr <= w_next_adr;
                        r_mem_stb <= 1'b1;
                        r_state   <= S_REQ;
                    end else if (!enable) begin
                        r_offset   <= '0;
                        r_base_cur <= w_base_in;
                        r_base_ack <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_mem_stb <= 1'b0;
                        r_beat    <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mem_dv) begin
                        r_fifo_stb <= 1'b1;
                        r_fifo_di  <= mem_di;
                        r_beat     <= ~r_beat;
                        if (r_beat) begin
                            r_state <= S_SETTLE;
                            if (w_wrap) begin
                                r_offset   <= '0;
                                r_base_cur <= w_base_in;
                                r_base_ack <= 1'b1;
                            end else begin
                                r_offset <= w_off_inc[17:0];
                            end
                        end
                    end
                end
                // Lets the last strobe land before fifo_can_burst is looked at again.
                S_SETTLE: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign base_ack = r_base_ack;
    assign fifo_stb = r_fifo_stb;
    assign fifo_di  = r_fifo_di;
    assign mem_stb  = r_mem_stb;
    assign mem_adr  = r_mem_adr;

endmodule
